// File: rtl/fifo_push_arbiter.sv
// Round-robin, packet-granular arbiter sharing one FIFO push port among N_REQ requesters.
// Latency: 1 idle arbitration cycle per grant; full stalls the owner, non-owners wait with valid held.
module fifo_push_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_BITS    = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*N_BITS-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_push,
    output logic [N_BITS-1:0]       fifo_data_in,
    output logic [N_REQ-1:0]        grant,
    output logic                    burst_err
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t             state, state_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
    logic               berr_nxt;

    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               win_found;
    int                 idx;

    // Scan from farthest to nearest so the nearest valid requester after rr_ptr wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = PTR_W'(idx);
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // While OWNED, rr_ptr always holds the owner index.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_nxt       = rr_ptr;
        cnt_nxt      = beat_cnt;
        berr_nxt     = 1'b0;
        req_ready    = '0;
        fifo_push    = 1'b0;
        fifo_data_in = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt          = OWNED;
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    rr_nxt             = win_idx;
                    cnt_nxt            = '0;
                end
            end
            OWNED: begin
                req_ready[rr_ptr] = !fifo_full;
                fifo_push         = req_valid[rr_ptr] && !fifo_full;
                fifo_data_in      = req_data[int'(rr_ptr)*N_BITS +: N_BITS];
                if (fifo_push) begin
                    if (req_last[rr_ptr] || beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                        berr_nxt  = !req_last[rr_ptr];
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            beat_cnt  <= '0;
            burst_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            beat_cnt  <= cnt_nxt;
            burst_err <= berr_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a per-cycle reference model and literal checks.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_push;
    logic [W-1:0]     fifo_data_in;
    logic [N-1:0]     grant;
    logic             burst_err;

    fifo_push_arbiter #(.N_REQ(N), .N_BITS(W), .MAX_BEATS(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_push    (fifo_push),
        .fifo_data_in (fifo_data_in),
        .grant        (grant),
        .burst_err    (burst_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: owner index (-1 = nobody), last winner, beats in this grant.
    int           own, rr, cnt, n_own, n_rr, n_cnt;
    logic         berr, n_berr;
    logic [N-1:0] e_grant, e_ready;
    logic         e_push;
    logic [W-1:0] e_data;
    logic         found;

    always_comb begin
        n_own   = own;
        n_rr    = rr;
        n_cnt   = cnt;
        n_berr  = 1'b0;
        e_grant = '0;
        e_ready = '0;
        e_push  = 1'b0;
        e_data  = '0;
        found   = 1'b0;
        if (own >= 0) begin
            e_grant = N'(1 << own);
            e_ready = fifo_full ? '0 : N'(1 << own);
            e_push  = ((req_valid >> own) & 1) != 0 && !fifo_full;
            e_data  = req_data[own*W +: W];
            if (e_push) begin
                n_cnt = cnt + 1;
                if (((req_last >> own) & 1) != 0) begin
                    n_own = -1;
                end else if (n_cnt == MB) begin
                    n_own  = -1;
                    n_berr = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!found && ((req_valid >> ((rr + k) % N)) & 1) != 0) begin
                    found = 1'b1;
                    n_own = (rr + k) % N;
                    n_rr  = (rr + k) % N;
                    n_cnt = 0;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own  <= -1;
            rr   <= N - 1;
            cnt  <= 0;
            berr <= 1'b0;
        end else begin
            own  <= n_own;
            rr   <= n_rr;
            cnt  <= n_cnt;
            berr <= n_berr;
        end
    end

    logic [W-1:0] push_q[$];
    logic [N-1:0] grant_q[$];
    logic [W-1:0] exp_q[$];
    logic [N-1:0] last_grant;
    int           berr_cnt;

    always @(negedge clk) begin
        tests = tests + 1;
        if ({req_ready, fifo_push, fifo_data_in, grant, burst_err} !==
            {e_ready, e_push, e_data, e_grant, berr}) begin
            fails = fails + 1;
            $display("FAIL model t=%0t: ready=%b push=%b data=%h grant=%b berr=%b, want ready=%b push=%b data=%h grant=%b berr=%b",
                     $time, req_ready, fifo_push, fifo_data_in, grant, burst_err,
                     e_ready, e_push, e_data, e_grant, berr);
        end
        if (fifo_push) push_q.push_back(fifo_data_in);
        if (burst_err) berr_cnt = berr_cnt + 1;
        if (grant != '0 && grant != last_grant) grant_q.push_back(grant);
        last_grant = grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, W'(push_q.size()), W'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < push_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), push_q[i], exp_q[i]);
        end
    endtask

    task automatic setd(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        push_q.delete();
        grant_q.delete();
        exp_q.delete();
        berr_cnt   = 0;
        last_grant = '0;
    endtask

    initial begin
        // 1: single requester, 3-beat packet
        do_reset();
        chk("rst_grant", W'(grant), 0);
        chk("rst_push", W'(fifo_push), 0);
        chk("rst_ready", W'(req_ready), 0);
        chk("rst_data", fifo_data_in, 0);
        chk("rst_berr", W'(burst_err), 0);
        req_valid = 4'b0001;
        setd(0, 64'hA0);
        tick();
        chk("t1_grant", W'(grant), 64'h1);
        chk("t1_push0", W'(fifo_push), 1);
        tick();
        setd(0, 64'hA1);
        chk("t1_push1", W'(fifo_push), 1);
        tick();
        setd(0, 64'hA2);
        req_last = 4'b0001;
        chk("t1_push2", W'(fifo_push), 1);
        tick();
        req_valid = '0;
        req_last  = '0;
        chk("t1_release", W'(grant), 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(64'hA0 + W'(i));
        chk_log("t1_log");

        // 2: all valid, 1-beat packets rotate round-robin
        do_reset();
        req_last = 4'b1111;
        for (int i = 0; i < N; i++) setd(i, 64'hB0 + W'(i));
        req_valid = 4'b1111;
        repeat (10) tick();
        req_valid = '0;
        req_last  = '0;
        chk("t2_ngrants", W'(grant_q.size()), 5);
        for (int i = 0; i < 5 && i < grant_q.size(); i++)
            chk($sformatf("t2_grant%0d", i), W'(grant_q[i]), W'(1 << (i % N)));
        for (int i = 0; i < 5; i++) exp_q.push_back(64'hB0 + W'(i % N));
        chk_log("t2_log");

        // 3: FIFO full stalls owner 2 mid-packet
        do_reset();
        req_valid = 4'b0100;
        setd(2, 64'hC0);
        tick();
        chk("t3_grant", W'(grant), 64'h4);
        tick();
        setd(2, 64'hC1);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t3_push_full%0d", i), W'(fifo_push), 0);
            chk($sformatf("t3_ready_full%0d", i), W'(req_ready), 0);
            chk($sformatf("t3_grant_full%0d", i), W'(grant), 64'h4);
            tick();
        end
        fifo_full = 1'b0;
        tick();
        setd(2, 64'hC2);
        req_last = 4'b0100;
        tick();
        req_valid = '0;
        req_last  = '0;
        chk("t3_release", W'(grant), 0);
        for (int i = 0; i < 3; i++) exp_q.push_back(64'hC0 + W'(i));
        chk_log("t3_log");

        // 4: owner 1 never ends its packet; forced release after MB beats (with a stall inside)
        do_reset();
        req_valid = 4'b1010;
        setd(3, 64'hF3);
        setd(1, 64'hD0);
        tick();
        chk("t4_grant", W'(grant), 64'h2);
        for (int k = 0; k < MB; k++) begin
            setd(1, 64'hD0 + W'(k));
            if (k == 5) begin
                fifo_full = 1'b1;
                tick();
                tick();
                fifo_full = 1'b0;
            end
            tick();
        end
        chk("t4_berr", W'(burst_err), 1);
        chk("t4_released", W'(grant), 0);
        tick();
        req_valid = '0;
        chk("t4_berr_off", W'(burst_err), 0);
        chk("t4_next_grant", W'(grant), 64'h8);
        for (int k = 0; k < MB; k++) exp_q.push_back(64'hD0 + W'(k));
        chk_log("t4_log");
        chk("t4_berr_pulses", W'(berr_cnt), 1);

        // 5: owner 3 bubbles while req 0 waits
        do_reset();
        req_valid = 4'b1000;
        setd(3, 64'hE0);
        setd(0, 64'hF0);
        tick();
        chk("t5_grant", W'(grant), 64'h8);
        tick();
        setd(3, 64'hE1);
        req_valid = 4'b1001;
        tick();
        req_valid = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("t5_bubble_push%0d", i), W'(fifo_push), 0);
            chk($sformatf("t5_bubble_grant%0d", i), W'(grant), 64'h8);
            tick();
        end
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        setd(3, 64'hE2);
        tick();
        chk("t5_release", W'(grant), 0);
        tick();
        chk("t5_grant0", W'(grant), 64'h1);
        tick();
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < 3; i++) exp_q.push_back(64'hE0 + W'(i));
        exp_q.push_back(64'hF0);
        chk_log("t5_log");

        // 6: asynchronous reset mid-burst
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) setd(i, 64'h60 + W'(i));
        tick();
        chk("t6_grant", W'(grant), 64'h1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", W'(grant), 0);
        chk("t6_async_push", W'(fifo_push), 0);
        chk("t6_async_ready", W'(req_ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_first_grant", W'(grant), 64'h1);
        req_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
